// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped LED PWM block: register offsets,
// funct3 access-size codes, the duty type and the DUTY register layout.
`timescale 1ns/1ps
package mmio_pkg;

    localparam int unsigned DATA_W = 32;

    // Register offsets within the 16-byte window
    localparam logic [3:0] DUTY_OFS   = 4'h0;
    localparam logic [3:0] CTRL_OFS   = 4'h4;
    localparam logic [3:0] STAT_OFS   = 4'h8;
    localparam logic [3:0] MILLIS_OFS = 4'hC;

    // funct3 access size / sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [7:0] pwm_duty_t;

    // DUTY register layout, blue in the top byte
    typedef struct packed {
        pwm_duty_t blue;
        pwm_duty_t green;
        pwm_duty_t red;
        pwm_duty_t led;
    } duty_reg_t;

    // Replace the byte lanes of old_w selected by be with those of new_w
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [3:0]        be
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// Single PWM channel: registered compare of the shared counter against a duty.
// Ports: i_clk, i_rst (async active-high), i_enable, i_cnt (shared pwm count),
//        i_duty (channel duty), o_pwm (registered channel drive).
`timescale 1ns/1ps
module pwm_channel
    import mmio_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_enable,
    input  pwm_duty_t i_cnt,
    input  pwm_duty_t i_duty,
    output logic      o_pwm
);

    // High for duty counts out of 256; duty 0 never fires
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pwm <= 1'b0;
        end else begin
            o_pwm <= i_enable && (i_cnt < i_duty);
        end
    end

endmodule

// File: rtl/mmio_led_pwm.sv
// Memory-mapped 4-channel LED PWM controller on a RISC-V style data bus.
// Registers: DUTY (0x0), CTRL (0x4, enable + prescale), STAT (0x8, pwm_cnt),
// MILLIS (0xC, free-running millisecond counter when MMIO_LED_PWM_MILLIS_EN
// is defined, otherwise reads 0).
// Ports: clk, reset (async active-high), funct3 (access size/sign),
//        dmem_wren, dmem_address, dmem_data_in (store side),
//        dmem_data_out (registered load data, one-cycle latency),
//        led/red/green/blue (registered PWM drives).
`timescale 1ns/1ps
module mmio_led_pwm
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned CLK_HZ    = 12_000_000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam logic [1:0] SEL_DUTY   = DUTY_OFS[3:2];
    localparam logic [1:0] SEL_CTRL   = CTRL_OFS[3:2];
    localparam logic [1:0] SEL_STAT   = STAT_OFS[3:2];
    localparam logic [1:0] SEL_MILLIS = MILLIS_OFS[3:2];

    duty_reg_t   r_duty;
    logic        r_enable;
    pwm_duty_t   r_prescale;
    pwm_duty_t   r_pre_cnt;
    pwm_duty_t   r_pwm_cnt;
    logic [31:0] r_millis_rd;

    logic        w_hit;
    logic [1:0]  w_sel;
    logic [1:0]  w_lane;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_wr_en;
    logic        w_wr_duty;
    logic        w_wr_ctrl;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_ctrl_next;
    logic [31:0] w_rd_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rd_data;
    logic        w_tick;

    assign w_hit  = (dmem_address[31:4] == BASE_ADDR[31:4]);
    assign w_sel  = dmem_address[3:2];
    assign w_lane = dmem_address[1:0];

    // Alignment check shared by loads and stores; unknown codes count as misaligned
    always_comb begin
        w_aligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: w_aligned = 1'b1;
            F3_H, F3_HU: w_aligned = ~w_lane[0];
            F3_W:        w_aligned = (w_lane == 2'b00);
            default:     w_aligned = 1'b0;
        endcase
    end

    // Store byte enables and lane-replicated store data
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = dmem_data_in;
        case (funct3)
            F3_B: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{dmem_data_in[7:0]}};
            end
            F3_H: begin
                if (w_aligned) w_be = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{dmem_data_in[15:0]}};
            end
            F3_W: begin
                if (w_aligned) w_be = 4'b1111;
            end
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wr_en     = dmem_wren && w_hit && (w_be != 4'b0000);
    assign w_wr_duty   = w_wr_en && (w_sel == SEL_DUTY);
    assign w_wr_ctrl   = w_wr_en && (w_sel == SEL_CTRL);
    assign w_ctrl_rd   = {16'h0000, r_prescale, 7'h00, r_enable};
    assign w_ctrl_next = merge_bytes(w_ctrl_rd, w_wdata, w_be);

    // Register read mux (current register values, so a same-cycle store is not visible)
    always_comb begin
        w_rd_word = 32'h0000_0000;
        case (w_sel)
            SEL_DUTY:   w_rd_word = r_duty;
            SEL_CTRL:   w_rd_word = w_ctrl_rd;
            SEL_STAT:   w_rd_word = {24'h000000, r_pwm_cnt};
            SEL_MILLIS: w_rd_word = r_millis_rd;
            default:    w_rd_word = 32'h0000_0000;
        endcase
    end

    assign w_byte = w_rd_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    // Lane extraction with sign/zero extension; misses and misaligned loads give 0
    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (w_hit && w_aligned) begin
            case (funct3)
                F3_B:    w_rd_data = {{24{w_byte[7]}}, w_byte};
                F3_BU:   w_rd_data = {24'h000000, w_byte};
                F3_H:    w_rd_data = {{16{w_half[15]}}, w_half};
                F3_HU:   w_rd_data = {16'h0000, w_half};
                F3_W:    w_rd_data = w_rd_word;
                default: w_rd_data = 32'h0000_0000;
            endcase
        end
    end

    // Bus-visible registers and load data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty        <= '0;
            r_enable      <= 1'b0;
            r_prescale    <= '0;
            dmem_data_out <= 32'h0000_0000;
        end else begin
            if (w_wr_duty) r_duty <= merge_bytes(r_duty, w_wdata, w_be);
            if (w_wr_ctrl) begin
                r_enable   <= w_ctrl_next[0];
                r_prescale <= w_ctrl_next[15:8];
            end
            dmem_data_out <= w_rd_data;
        end
    end

    assign w_tick = r_enable && (r_pre_cnt == r_prescale);

    // Prescaler and PWM counter; a CTRL store restarts both, disable freezes both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (w_wr_ctrl) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (r_enable) begin
            if (w_tick) begin
                r_pre_cnt <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_pre_cnt <= r_pre_cnt + 8'd1;
            end
        end
    end

    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{w_ctrl_next[31:16], w_ctrl_next[7:1]};

`ifdef MMIO_LED_PWM_MILLIS_EN
    localparam int unsigned MS_DIV   = (CLK_HZ / 1000 > 0) ? (CLK_HZ / 1000) : 1;
    localparam int unsigned MS_DIV_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [MS_DIV_W-1:0] r_ms_div;
    logic [31:0]         r_millis;
    logic                w_wr_millis;

    // Only a full aligned word store preloads MILLIS
    assign w_wr_millis = w_wr_en && (w_sel == SEL_MILLIS) && (w_be == 4'b1111);

    // Millisecond counter, runs regardless of enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_div <= '0;
            r_millis <= 32'h0000_0000;
        end else if (w_wr_millis) begin
            r_ms_div <= '0;
            r_millis <= dmem_data_in;
        end else if (r_ms_div == MS_DIV_W'(MS_DIV - 1)) begin
            r_ms_div <= '0;
            r_millis <= r_millis + 32'd1;
        end else begin
            r_ms_div <= r_ms_div + MS_DIV_W'(1);
        end
    end

    assign r_millis_rd = r_millis;
`else
    logic w_unused_clk_hz;
    assign w_unused_clk_hz = ^CLK_HZ;
    assign r_millis_rd     = 32'h0000_0000;
`endif

    pwm_channel u_led (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_enable (r_enable),
        .i_cnt    (r_pwm_cnt),
        .i_duty   (r_duty.led),
        .o_pwm    (led)
    );

    pwm_channel u_red (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_enable (r_enable),
        .i_cnt    (r_pwm_cnt),
        .i_duty   (r_duty.red),
        .o_pwm    (red)
    );

    pwm_channel u_green (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_enable (r_enable),
        .i_cnt    (r_pwm_cnt),
        .i_duty   (r_duty.green),
        .o_pwm    (green)
    );

    pwm_channel u_blue (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_enable (r_enable),
        .i_cnt    (r_pwm_cnt),
        .i_duty   (r_duty.blue),
        .o_pwm    (blue)
    );

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Self-checking bench for mmio_led_pwm: a table of single-cycle bus accesses
// with expected load data, then hand-written multi-cycle sequences for PWM
// duty, prescale/wrap, asynchronous reset and MILLIS.
`timescale 1ns/1ps
module tb_mmio_led_pwm;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef MMIO_LED_PWM_MILLIS_EN
    localparam int unsigned TB_CLK_HZ = 4000;
`else
    localparam int unsigned TB_CLK_HZ = 12_000_000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  funct3;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        led, red, green, blue;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    mmio_led_pwm #(
        .BASE_ADDR (BASE),
        .CLK_HZ    (TB_CLK_HZ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .funct3        (funct3),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .led           (led),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; the store strobe is dropped again after the edge
    task automatic access(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd);
        dmem_wren    = wr;
        dmem_address = addr;
        funct3       = f3;
        dmem_data_in = wd;
        step();
        dmem_wren    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_led, cnt_red, cnt_green, cnt_blue, errs, waited;
        logic [31:0] exp_stat;

        vecs[0]  = '{1'b1, BASE + 32'h0,  F3_W,   32'h80FF_4010, 32'h0000_0000};
        vecs[1]  = '{1'b0, BASE + 32'h3,  F3_B,   32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b0, BASE + 32'h3,  F3_BU,  32'h0,         32'h0000_0080};
        vecs[3]  = '{1'b0, BASE + 32'h2,  F3_H,   32'h0,         32'hFFFF_80FF};
        vecs[4]  = '{1'b0, BASE + 32'h2,  F3_HU,  32'h0,         32'h0000_80FF};
        vecs[5]  = '{1'b0, BASE + 32'h0,  F3_W,   32'h0,         32'h80FF_4010};
        vecs[6]  = '{1'b0, BASE + 32'h0,  F3_B,   32'h0,         32'h0000_0010};
        vecs[7]  = '{1'b0, BASE + 32'h1,  F3_B,   32'h0,         32'h0000_0040};
        vecs[8]  = '{1'b1, BASE + 32'h1,  F3_H,   32'h0000_1234, 32'h0000_0000};
        vecs[9]  = '{1'b0, BASE + 32'h0,  F3_W,   32'h0,         32'h80FF_4010};
        vecs[10] = '{1'b0, BASE + 32'h2,  F3_W,   32'h0,         32'h0000_0000};
        vecs[11] = '{1'b1, BASE + 32'h1,  F3_B,   32'h0000_00AB, 32'h0000_0040};
        vecs[12] = '{1'b0, BASE + 32'h0,  F3_W,   32'h0,         32'h80FF_AB10};
        vecs[13] = '{1'b1, BASE + 32'h2,  F3_H,   32'h0000_5566, 32'hFFFF_80FF};
        vecs[14] = '{1'b0, BASE + 32'h0,  F3_W,   32'h0,         32'h5566_AB10};
        vecs[15] = '{1'b1, BASE + 32'h10, F3_W,   32'hFFFF_FFFF, 32'h0000_0000};
        vecs[16] = '{1'b0, BASE + 32'h10, F3_W,   32'h0,         32'h0000_0000};
        vecs[17] = '{1'b0, BASE + 32'h0,  F3_W,   32'h0,         32'h5566_AB10};
        vecs[18] = '{1'b0, BASE + 32'h4,  F3_W,   32'h0,         32'h0000_0000};
        vecs[19] = '{1'b1, BASE + 32'h8,  F3_W,   32'h0000_00FF, 32'h0000_0000};
        vecs[20] = '{1'b0, BASE + 32'h8,  F3_W,   32'h0,         32'h0000_0000};
        vecs[21] = '{1'b1, BASE + 32'h4,  F3_W,   32'hFFFF_FF00, 32'h0000_0000};
        vecs[22] = '{1'b0, BASE + 32'h4,  F3_W,   32'h0,         32'h0000_FF00};
        vecs[23] = '{1'b0, BASE + 32'h5,  F3_BU,  32'h0,         32'h0000_00FF};
        vecs[24] = '{1'b0, BASE + 32'h5,  F3_B,   32'h0,         32'hFFFF_FFFF};
        vecs[25] = '{1'b0, BASE + 32'h4,  F3_HU,  32'h0,         32'h0000_FF00};
        vecs[26] = '{1'b1, BASE + 32'h4,  F3_W,   32'h0000_0000, 32'h0000_FF00};
        vecs[27] = '{1'b0, BASE + 32'h4,  F3_W,   32'h0,         32'h0000_0000};
        vecs[28] = '{1'b0, BASE + 32'h0,  3'b011, 32'h0,         32'h0000_0000};
        vecs[29] = '{1'b0, BASE + 32'h4,  F3_B,   32'h0,         32'h0000_0000};
        vecs[30] = '{1'b0, 32'hFFFF_FEF0, F3_W,   32'h0,         32'h0000_0000};

        reset        = 1'b1;
        funct3       = F3_W;
        dmem_wren    = 1'b0;
        dmem_address = 32'h0;
        dmem_data_in = 32'h0;
        step();
        check("reset_data_out", dmem_data_out, 32'h0);
        check("reset_channels", {28'h0, led, red, green, blue}, 32'h0);
        step();
        reset = 1'b0;
        step();

        access(1'b0, BASE + 32'h0, F3_W, 32'h0);
        check("reset_duty", dmem_data_out, 32'h0);
        access(1'b0, BASE + 32'h4, F3_W, 32'h0);
        check("reset_ctrl", dmem_data_out, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].f3, vecs[i].wd);
            check($sformatf("vec%0d", i), dmem_data_out, vecs[i].exp);
        end

        // PWM duty: blue 255, green 0, red 64, led 0, P=0
        access(1'b1, BASE + 32'h0, F3_W, 32'hFF00_4000);
        access(1'b1, BASE + 32'h4, F3_W, 32'h0000_0001);
        repeat (4) step();
        cnt_led = 0; cnt_red = 0; cnt_green = 0; cnt_blue = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            cnt_led   += int'(led);
            cnt_red   += int'(red);
            cnt_green += int'(green);
            cnt_blue  += int'(blue);
        end
        check("pwm_red_64",    32'(cnt_red),   32'd64);
        check("pwm_green_0",   32'(cnt_green), 32'd0);
        check("pwm_led_0",     32'(cnt_led),   32'd0);
        check("pwm_blue_255",  32'(cnt_blue),  32'd255);

        // Prescale 3: pwm_cnt advances every 4 cycles and wraps after 1024
        access(1'b1, BASE + 32'h4, F3_W, 32'h0000_0301);
        dmem_address = BASE + 32'h8;
        funct3       = F3_W;
        errs         = 0;
        for (int j = 1; j <= 1025; j++) begin
            step();
            exp_stat = 32'(((j - 1) / 4) % 256);
            if (dmem_data_out !== exp_stat) errs++;
            if (j == 4)    check("stat_j4",       dmem_data_out, 32'd0);
            if (j == 5)    check("stat_j5",       dmem_data_out, 32'd1);
            if (j == 1024) check("stat_pre_wrap", dmem_data_out, 32'd255);
            if (j == 1025) check("stat_wrap",     dmem_data_out, 32'd0);
        end
        check("prescale_seq_errs", 32'(errs), 32'd0);

        // Disable freezes counters and drives channels low
        access(1'b1, BASE + 32'h4, F3_B, 32'h0000_0000);
        repeat (3) step();
        check("disabled_channels", {28'h0, led, red, green, blue}, 32'h0);

        // Asynchronous reset mid-period while channels are high
        access(1'b1, BASE + 32'h4, F3_W, 32'h0000_0001);
        dmem_address = BASE + 32'h0;
        funct3       = F3_W;
        waited       = 0;
        step();
        while (red !== 1'b1 && waited < 300) begin
            step();
            waited++;
        end
        check("red_high_before_reset", {31'h0, red}, 32'h1);
        check("duty_before_reset", dmem_data_out, 32'hFF00_4000);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_channels", {28'h0, led, red, green, blue}, 32'h0);
        check("async_reset_data_out", dmem_data_out, 32'h0);
        step();
        #2;
        reset = 1'b0;
        access(1'b0, BASE + 32'h8, F3_W, 32'h0);
        check("post_reset_stat", dmem_data_out, 32'h0);
        access(1'b0, BASE + 32'h0, F3_W, 32'h0);
        check("post_reset_duty", dmem_data_out, 32'h0);
        access(1'b0, BASE + 32'h4, F3_W, 32'h0);
        check("post_reset_ctrl", dmem_data_out, 32'h0);

`ifdef MMIO_LED_PWM_MILLIS_EN
        // Preload all-ones: divider of 4 rolls MILLIS to 0 four edges later
        access(1'b1, BASE + 32'hC, F3_W, 32'hFFFF_FFFF);
        dmem_address = BASE + 32'hC;
        funct3       = F3_W;
        for (int j = 1; j <= 5; j++) begin
            step();
            if (j == 4) check("millis_before_wrap", dmem_data_out, 32'hFFFF_FFFF);
            if (j == 5) check("millis_wrapped",     dmem_data_out, 32'h0);
        end
`else
        access(1'b1, BASE + 32'hC, F3_W, 32'h1234_5678);
        check("millis_absent_store", dmem_data_out, 32'h0);
        access(1'b0, BASE + 32'hC, F3_W, 32'h0);
        check("millis_absent_read", dmem_data_out, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
